// File: rtl/clock_ui_pkg.sv
// clock_ui_pkg: types and constants shared by the clock time-set panel logic.
//   key_state_t : per-key command FSM state (IDLE, HOLD, REPEAT, LOCK, PRESSED)
//   *_50M       : default cycle counts for a 50 MHz clock
package clock_ui_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    REPEAT,
    LOCK,
    PRESSED
  } key_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_50M = 20000;     // 0.4 ms
  localparam int unsigned HOLD_CYCLES_50M     = 25000000;  // 0.5 s
  localparam int unsigned REPEAT_CYCLES_50M   = 5000000;   // 0.1 s

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus debounce filter for one push-button.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset
//   raw_i       : raw, asynchronous, bouncy key input (active-high)
//   level_o     : registered debounced key state
//   level_nxt_o : value level_o takes at the next edge, so downstream logic
//                 can register a pulse in the same cycle the level changes
module key_debounce
  import clock_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic level_nxt_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter holds the number of disagreeing cycles already seen; the cycle
  // that would make it DEBOUNCE_CYCLES flips the level instead, so it never
  // exceeds DEBOUNCE_CYCLES-1.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o     = level_q;
  assign level_nxt_o = level_d;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: turns the raw increment/decrement buttons into clean,
// interlocked single-cycle command pulses for the mod-M digit counters.
//   clk         : sole clock
//   rst         : asynchronous active-low reset
//   key_inc_raw : raw increment button
//   key_dec_raw : raw decrement button
//   inc_pulse   : one-cycle increment command
//   dec_pulse   : one-cycle decrement command
//   inc_level   : debounced increment key state
//   dec_level   : debounced decrement key state
// Build option KEY_AUTOREPEAT_EN: when defined, a held key auto-repeats
// (IDLE/HOLD/REPEAT/LOCK); otherwise one pulse per press (IDLE/PRESSED/LOCK).
module key_conditioner
  import clock_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_50M,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_50M
) (
  input  logic clk,
  input  logic rst,
  input  logic key_inc_raw,
  input  logic key_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  // Index 0 = increment key, index 1 = decrement key.
  logic [1:0] lvl;
  logic [1:0] lvl_nxt;
  logic [1:0] pulse_q;
  logic       both_held;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk_i       (clk),
    .rst_ni      (rst),
    .raw_i       (key_inc_raw),
    .level_o     (lvl[0]),
    .level_nxt_o (lvl_nxt[0])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk_i       (clk),
    .rst_ni      (rst),
    .raw_i       (key_dec_raw),
    .level_o     (lvl[1]),
    .level_nxt_o (lvl_nxt[1])
  );

  // FSMs act on the next-cycle levels so pulses and levels move on the same
  // edge; this also catches simultaneous rises before either key can pulse.
  assign both_held = &lvl_nxt;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX);
`else
  // Timing parameters have no logic in this build; kept for a uniform interface.
  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_unused_timing
  end
`endif

  for (genvar k = 0; k < 2; k++) begin : g_fsm
    key_state_t state_q;
`ifdef KEY_AUTOREPEAT_EN
    logic [TW-1:0] timer_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q    <= IDLE;
        pulse_q[k] <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        timer_q    <= '0;
`endif
      end else begin
        pulse_q[k] <= 1'b0;
        if (both_held) begin
          state_q <= LOCK;
        end else begin
          case (state_q)
            IDLE: begin
              if (lvl_nxt[k] && !lvl[k]) begin
                pulse_q[k] <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                state_q    <= HOLD;
                timer_q    <= '0;
`else
                state_q    <= PRESSED;
`endif
              end
            end
`ifdef KEY_AUTOREPEAT_EN
            HOLD: begin
              if (!lvl_nxt[k]) begin
                state_q <= IDLE;
              end else if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                pulse_q[k] <= 1'b1;
                timer_q    <= '0;
                state_q    <= REPEAT;
              end else begin
                timer_q <= timer_q + 1'b1;
              end
            end
            REPEAT: begin
              if (!lvl_nxt[k]) begin
                state_q <= IDLE;
              end else if (timer_q == TW'(REPEAT_CYCLES - 1)) begin
                pulse_q[k] <= 1'b1;
                timer_q    <= '0;
              end else begin
                timer_q <= timer_q + 1'b1;
              end
            end
`else
            PRESSED: begin
              if (!lvl_nxt[k]) state_q <= IDLE;
            end
`endif
            LOCK: begin
              if (!lvl_nxt[k]) state_q <= IDLE;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign inc_pulse = pulse_q[0];
  assign dec_pulse = pulse_q[1];
  assign inc_level = lvl[0];
  assign dec_level = lvl[1];

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus randomised key traffic, every
// cycle compared with a behavioural model built from press/release rules.
module tb_key_conditioner;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inc_raw = 1'b0;
  logic dec_raw = 1'b0;
  logic inc_pulse, dec_pulse, inc_level, dec_level;

  key_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_inc_raw (inc_raw),
    .key_dec_raw (dec_raw),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .inc_level   (inc_level),
    .dec_level   (dec_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // scenario statistics
  int n_inc, n_dec, first_inc, first_dec, fall_inc;
  logic prev_inc;

  // behavioural model
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_lvl [2];
  bit m_act [2];
  bit m_lock [2];
  bit m_pulse [2];
  int m_run [2];
  int m_press [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_act[k] = 0;
      m_lock[k] = 0; m_pulse[k] = 0; m_run[k] = 0; m_press[k] = 0;
    end
  endtask

  // One clock edge: level flips after D consecutive disagreeing synchronised
  // samples; a pressed key pulses at age 0, H, H+R, H+2R ... after its press.
  task automatic model_edge(input bit r0, input bit r1);
    bit nl [2];
    bit raw [2];
    int age;
    raw[0] = r0; raw[1] = r1;
    for (int k = 0; k < 2; k++) begin
      nl[k] = m_lvl[k];
      if (m_s2[k] != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == D) begin
          nl[k] = ~m_lvl[k];
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
    end
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 0;
      if (nl[0] && nl[1]) begin
        m_lock[k] = 1; m_act[k] = 0;
      end else if (m_lock[k]) begin
        if (!nl[k]) m_lock[k] = 0;
      end else if (m_act[k]) begin
        if (!nl[k]) m_act[k] = 0;
        else if (AR) begin
          age = cyc_n - m_press[k];
          if (age >= H && (age - H) % R == 0) m_pulse[k] = 1;
        end
      end else if (nl[k] && !m_lvl[k]) begin
        m_act[k] = 1; m_press[k] = cyc_n; m_pulse[k] = 1;
      end
    end
    for (int k = 0; k < 2; k++) m_lvl[k] = nl[k];
  endtask

  task automatic clear_stats();
    n_inc = 0; n_dec = 0; first_inc = -1; first_dec = -1; fall_inc = -1;
  endtask

  task automatic cyc();
    cyc_n++;
    if (!rst) model_reset();
    else model_edge(inc_raw, dec_raw);
    @(posedge clk);
    #1;
    chk("inc_level", inc_level, m_lvl[0]);
    chk("dec_level", dec_level, m_lvl[1]);
    chk("inc_pulse", inc_pulse, m_pulse[0]);
    chk("dec_pulse", dec_pulse, m_pulse[1]);
    chk("pulse_excl", inc_pulse & dec_pulse, 0);
    if (inc_pulse) begin n_inc++; if (first_inc < 0) first_inc = cyc_n; end
    if (dec_pulse) begin n_dec++; if (first_dec < 0) first_dec = cyc_n; end
    if (prev_inc && !inc_level) fall_inc = cyc_n;
    prev_inc = inc_level;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // Pulses for a key whose raw input is held for t sampled edges.
  function automatic int exp_pulses(input int t);
    if (!AR || t - 1 < H) return 1;
    return 1 + (t - 1 - H) / R + 1;
  endfunction

  int k0, kd;

  initial begin
    prev_inc = 1'b0;
    model_reset();
    clear_stats();

    // reset state
    run(3);
    rst = 1'b1;
    run(3);

    // bounce rejection
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      inc_raw = ~inc_raw;
      run(3);
    end
    inc_raw = 1'b0;
    run(10);
    chk("bounce_pulses", n_inc, 0);
    chk("bounce_level", inc_level, 0);

    // clean press
    clear_stats();
    inc_raw = 1'b1;
    k0 = cyc_n + 1;
    run(15);
    inc_raw = 1'b0;
    kd = cyc_n + 1;
    run(10);
    chk("press_count", n_inc, 1);
    chk("press_edge", first_inc, k0 + 1 + D);
    chk("release_edge", fall_inc, kd + 1 + D);

    // auto-repeat on dec
    clear_stats();
    dec_raw = 1'b1;
    k0 = cyc_n + 1;
    run(64);
    dec_raw = 1'b0;
    run(D + 1);
    chk("repeat_first", first_dec, k0 + 1 + D);
    chk("repeat_count", n_dec, exp_pulses(64));
    clear_stats();
    run(12);
    chk("after_release", n_dec, 0);

    // interlock
    inc_raw = 1'b1;
    run(D + 1 + H + 3);
    dec_raw = 1'b1;
    run(D + 1);
    clear_stats();
    run(7);
    dec_raw = 1'b0;
    run(20);
    chk("lock_still_held", n_inc + n_dec, 0);
    inc_raw = 1'b0;
    run(10);
    chk("lock_released", n_inc + n_dec, 0);
    clear_stats();
    inc_raw = 1'b1;
    run(10);
    inc_raw = 1'b0;
    run(10);
    chk("repress_count", n_inc, 1);

    // reset mid-hold
    inc_raw = 1'b1;
    run(D + 1 + H + 7);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_inc_pulse", inc_pulse, 0);
    chk("rst_dec_pulse", dec_pulse, 0);
    chk("rst_inc_level", inc_level, 0);
    chk("rst_dec_level", dec_level, 0);
    run(2);
    rst = 1'b1;
    clear_stats();
    k0 = cyc_n + 1;
    run(8);
    chk("rst_repress_edge", first_inc, k0 + 1 + D);
    inc_raw = 1'b0;
    run(10);

    // long hold on inc
    clear_stats();
    inc_raw = 1'b1;
    run(60);
    inc_raw = 1'b0;
    run(12);
    chk("hold60_count", n_inc, exp_pulses(60));

    // randomised traffic on both keys
    for (int s = 0; s < 80; s++) begin
      case ($urandom_range(0, 3))
        0: inc_raw = ~inc_raw;
        1: dec_raw = ~dec_raw;
        2: begin inc_raw = 1'($urandom); dec_raw = 1'($urandom); end
        default: begin inc_raw = 1'b0; dec_raw = 1'b0; end
      endcase
      run($urandom_range(1, 35));
    end
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    run(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
